axi_lite_ram_slave: RTL and testbench

//  AXI4-Lite responder backed by a word-addressed on-chip RAM. It is the memory-side

---
 rtl/axi_lite_ram_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_ram_slave
//  Purpose  : AXI4-Lite responder backed by a word-addressed on-chip RAM.
//             Independent write (AW/W/B) and read (AR/R) state machines,
//             byte strobes honoured, out-of-window accesses answer DECERR.
//  Ports    : clk, reset_n (async, active-low)
//             AW : s_axi_awaddr/awprot/awvalid -> s_axi_awready
//             W  : s_axi_wdata/wstrb/wvalid    -> s_axi_wready
//             B  : s_axi_bresp/bvalid          <- s_axi_bready
//             AR : s_axi_araddr/arprot/arvalid -> s_axi_arready
//             R  : s_axi_rdata/rresp/rvalid    <- s_axi_rready
//  Revision : 1.0  initial release
// ============================================================================
module axi_lite_ram_slave #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // write address channel
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data channel
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response channel
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data channel
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned c_IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] c_WIN_BYTES  = 64'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  c_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  c_RESP_DEC   = 2'b11;

    typedef enum logic [0:0] {WR_ACCEPT = 1'b0, WR_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_ACCEPT = 1'b0, RD_RESP = 1'b1} rd_state_t;

    // Window check done on the offset so a BASE_ADDR near the top of the
    // address space cannot wrap around.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (64'(off) < c_WIN_BYTES);
    endfunction

    function automatic logic [c_IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return c_IDX_W'(off >> 2);
    endfunction

    // ------------------------------------------------------------------------
    // Storage (never reset; contents survive reset_n)
    // ------------------------------------------------------------------------
    logic [31:0] ram_q [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    wr_state_t             wr_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  aw_held_q;
    logic                  w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_fire;
    logic                  w_wr_in_range;
    logic [c_IDX_W-1:0]    w_wr_idx;

    assign w_aw_hs       = s_axi_awvalid && awready_q;
    assign w_w_hs        = s_axi_wvalid  && wready_q;
    // The RAM update happens one edge after both halves are captured.
    assign w_wr_fire     = (wr_state_q == WR_ACCEPT) && aw_held_q && w_held_q;
    assign w_wr_in_range = addr_in_range(awaddr_q);
    assign w_wr_idx      = word_idx(awaddr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q <= WR_ACCEPT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= c_RESP_OKAY;
        end else begin
            case (wr_state_q)
                WR_ACCEPT: begin
                    if (w_aw_hs) begin
                        awaddr_q  <= s_axi_awaddr;
                        aw_held_q <= 1'b1;
                    end
                    if (w_w_hs) begin
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        w_held_q <= 1'b1;
                    end
                    // Each ready stays up until its own beat is held; this
                    // also raises them on the first edge out of reset.
                    awready_q <= !(aw_held_q || w_aw_hs);
                    wready_q  <= !(w_held_q  || w_w_hs);
                    if (w_wr_fire) begin
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= w_wr_in_range ? c_RESP_OKAY : c_RESP_DEC;
                        wr_state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid_q && s_axi_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_ACCEPT;
                    end
                end
                default: wr_state_q <= WR_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire && w_wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram_q[w_wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    rd_state_t          rd_state_q;
    logic               arready_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic [1:0]         rresp_q;

    logic               w_ar_hs;
    logic               w_rd_in_range;
    logic [c_IDX_W-1:0] w_rd_idx;

    assign w_ar_hs       = s_axi_arvalid && arready_q;
    assign w_rd_in_range = addr_in_range(s_axi_araddr);
    assign w_rd_idx      = word_idx(s_axi_araddr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q <= RD_ACCEPT;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= c_RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_ACCEPT: begin
                    if (w_ar_hs) begin
                        // ram_q is sampled before this edge's write lands, so
                        // a same-edge write to the same word returns old data.
                        rdata_q    <= w_rd_in_range ? ram_q[w_rd_idx] : 32'h0;
                        rresp_q    <= w_rd_in_range ? c_RESP_OKAY : c_RESP_DEC;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rvalid_q && s_axi_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_ACCEPT;
                    end
                end
                default: rd_state_q <= RD_ACCEPT;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    // Protection attributes carry no meaning for this memory.
    logic w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_ram_slave
//  Purpose  : Self-checking bench for axi_lite_ram_slave: directed vector
//             table, collision and reset sequences, randomized traffic
//             against a word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_ram_slave;

    localparam int unsigned    DEPTH = 4096;
    localparam logic [31:0]    BASE  = 32'h0000_0000;
    localparam int             TMO   = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    axi_lite_ram_slave #(
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got no handshake within %0d cycles expected handshake", name, TMO);
    endtask

    function automatic logic [40:0] all_outs();
        return {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata};
    endfunction

    // Full write transaction with protocol checks; entered/left just after an edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int t;
        aw_done = 0; w_done = 0; t = 0; resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done  && (t >= w_dly);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            @(posedge clk); #1; t++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            if (t > TMO) begin
                awvalid = 0; wvalid = 0;
                timeout("aw_w_handshake");
                return;
            end
        end
        awvalid = 0; wvalid = 0;
        check("bvalid_not_early", bvalid, 1'b0);
        @(posedge clk); #1;
        check("bvalid_latency_readies_low", {bvalid, awready, wready}, 3'b100);
        resp = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            check("b_hold", {bvalid, bresp, awready, wready}, {1'b1, resp, 2'b00});
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("b_done_readies_up", {bvalid, awready, wready}, 3'b011);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done, hs;
        int t;
        done = 0; t = 0; data = 'x; resp = 2'bxx;
        araddr = addr;
        while (!done) begin
            arvalid = (t >= ar_dly);
            hs = arvalid && arready;
            @(posedge clk); #1; t++;
            if (hs) done = 1;
            if (t > TMO) begin
                arvalid = 0;
                timeout("ar_handshake");
                return;
            end
        end
        arvalid = 0;
        check("rvalid_latency_arready_low", {rvalid, arready}, 2'b10);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            check("r_hold", {rvalid, arready, rdata, rresp}, {1'b1, 1'b0, data, resp});
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("r_done_arready_up", {rvalid, arready}, 2'b01);
    endtask

    // Reference model: sparse word array, window rule in plain arithmetic.
    logic [31:0] model_mem [int];

    function automatic bit model_in_range(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d0;     // aw delay (write) / ar delay (read)
        int          d1;     // w delay (write)
        int          d2;     // bready delay (write) / rready delay (read)
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AB00, 4'h2, 3, 0, 0, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEAD_ABEF};
        vecs[4]  = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b11, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 0, 0, 0, 2'b11, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF, 0, 0, 5, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 4, 2'b00, 32'h55AA_55AA};
        vecs[10] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 1, 1, 0, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2, 0, 0, 2'b00, 32'h55AA_55AA};
        vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 0, 2, 1, 2'b11, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEAD_ABEF};
        vecs[14] = '{1'b1, 32'h0000_0012, 32'h00FF_0000, 4'h4, 0, 2, 0, 2'b00, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEFF_ABEF};

        // ---- power-on reset ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_outs(), 41'h0);
        reset_n = 1;
        check("readies_low_before_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check("readies_up_after_release", {awready, wready, arready}, 3'b111);

        // ---- directed vector table ----
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                          vecs[i].d0, vecs[i].d1, vecs[i].d2, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, vecs[i].d0, vecs[i].d2, rd, resp);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // ---- write/read collision on the same word ----
        axi_write(32'h20, 32'h1111_1111, 4'hF, 0, 0, 0, resp);
        check("coll_first_bresp", resp, 2'b00);
        begin
            logic [1:0]  wresp;
            logic [1:0]  rresp_l;
            logic [31:0] rd_l;
            fork
                axi_write(32'h20, 32'h2222_2222, 4'hF, 0, 0, 0, wresp);
                axi_read(32'h20, 1, 0, rd_l, rresp_l);
            join
            check("coll_same_edge_old_data", rd_l, 32'h1111_1111);
            check("coll_second_bresp", wresp, 2'b00);
        end
        axi_read(32'h20, 0, 0, rd, resp);
        check("coll_later_new_data", rd, 32'h2222_2222);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 16; k++) begin
            logic [31:0] a, d;
            a = 32'h200 + 32'(4 * k);
            d = $urandom();
            axi_write(a, d, 4'hF, 0, 0, 0, resp);
            model_mem[model_idx(a)] = d;
            check("rnd_init_bresp", resp, 2'b00);
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d, mask, exp_d;
            logic [3:0]  s;
            logic [1:0]  exp_r;
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h4000 + 32'($urandom_range(0, 255))
                                                 : ($urandom() | 32'h8000_0000);
            else
                a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            exp_r = model_in_range(a) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), resp);
                check("rnd_bresp", resp, exp_r);
                if (model_in_range(a)) begin
                    mask = 0;
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mask = mask | (32'hFF << (8 * b));
                    model_mem[model_idx(a)] = (model_mem[model_idx(a)] & ~mask) | (d & mask);
                end
            end else begin
                axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp);
                exp_d = model_in_range(a) ? model_mem[model_idx(a)] : 32'h0;
                check("rnd_rresp", resp, exp_r);
                check("rnd_rdata", rd, exp_d);
            end
        end

        // ---- reset with write response and read data pending ----
        awaddr = 32'h50; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; araddr = 32'h10;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(posedge clk); #1;
        check("pending_b_and_r", {bvalid, rvalid}, 2'b11);
        reset_n = 0;
        #2;
        check("midrun_reset_outputs_zero_a", all_outs(), 41'h0);
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        check("readies_up_after_reset_a", {awready, wready, arready, bvalid}, 4'b1110);

        // ---- reset with AW captured but W missing ----
        awaddr = 32'h60; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        check("aw_held_w_waiting", {awready, wready}, 2'b01);
        reset_n = 0;
        #2;
        check("midrun_reset_outputs_zero_b", all_outs(), 41'h0);
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        check("readies_up_after_reset_b", {awready, wready, arready}, 3'b111);

        axi_write(32'h70, 32'h0BAD_CAFE, 4'hF, 2, 0, 0, resp);
        check("post_reset_write_bresp", resp, 2'b00);
        axi_read(32'h70, 0, 0, rd, resp);
        check("post_reset_read_new", rd, 32'h0BAD_CAFE);
        axi_read(32'h50, 0, 0, rd, resp);
        check("ram_kept_pending_write", rd, 32'hA5A5_A5A5);
        axi_read(32'h10, 0, 0, rd, resp);
        check("ram_kept_across_reset", rd, 32'hDEFF_ABEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
